// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Request/response bundle between the two ALU requesters and the
//   shared-ALU arbiter. Both ports are packed side by side: bit i (or the
//   i-th field) of every vector belongs to port i.
//   req_valid/req_ready : per-port request handshake
//   req_op              : 4-bit ALU control code per port, port i in [4i+3:4i]
//   req_a/req_b         : 32-bit operands per port, port i in [32i+31:32i]
//   rsp_valid/rsp_ready : per-port response handshake
//   rsp_data/rsp_err    : result and illegal-op flag, shared by both ports
//   master = requester side, slave = arbiter side.
interface alu_share_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one 32-bit ALU between two requesters (port 0: core execute,
//   port 1: debug/aux). One operation in flight; round-robin on ties.
//   The ALU operands are launched from registers, the result is sampled
//   ALU_LAT cycles later and returned on the owner's response channel.
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : request/response bundle, see alu_share_arbiter_if
//   alu_ctrl_o     : 4-bit ALU control code (held until next launch)
//   alu_a_o/_b_o   : ALU operands (held until next launch)
//   alu_start_o    : one-cycle pulse on operand launch
//   alu_result_i   : ALU result, sampled ALU_LAT cycles after launch
//   busy_o         : high whenever the arbiter is not idle
module alu_share_arbiter #(
  parameter int ALU_LAT = 1  // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus,
  output logic [3:0]           alu_ctrl_o,
  output logic [31:0]          alu_a_o,
  output logic [31:0]          alu_b_o,
  output logic                 alu_start_o,
  input  logic [31:0]          alu_result_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        alu_start_q, alu_start_d;

  logic        winner;
  logic [3:0]  win_op;
  logic [31:0] win_a, win_b;
  logic        win_legal;
  logic        accept;

  // Round-robin pick: a sole requester wins, a tie goes to the port that
  // did not win last time.
  always_comb begin
    case (bus.req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_q;
      default: winner = 1'b0;
    endcase
  end

  assign win_op    = winner ? bus.req_op[7:4]  : bus.req_op[3:0];
  assign win_a     = winner ? bus.req_a[63:32] : bus.req_a[31:0];
  assign win_b     = winner ? bus.req_b[63:32] : bus.req_b[31:0];
  assign win_legal = (win_op != 4'd0) && (win_op <= 4'd10);

  // req_ready is forced low while reset is asserted so no handshake can be
  // seen during reset even though the state register already reads IDLE.
  assign bus.req_ready = (state_q == IDLE && !reset && (|bus.req_valid))
                         ? {winner, ~winner} : 2'b00;
  assign accept = |(bus.req_valid & bus.req_ready);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = EXEC;
          if (win_legal) begin
            alu_ctrl_d  = win_op;
            alu_a_d     = win_a;
            alu_b_d     = win_b;
            alu_start_d = 1'b1;
            cnt_d       = 4'(ALU_LAT - 1);
            rsp_err_d   = 1'b0;
          end else begin
            // Illegal ops pass through EXEC for one cycle with the error
            // response already loaded, so the error answer appears one
            // cycle after accept; the ALU is left untouched.
            rsp_data_d = 32'd0;
            rsp_err_d  = 1'b1;
            cnt_d      = 4'd0;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          // rsp_err_q set here marks an illegal op: keep the zero result.
          if (!rsp_err_q) rsp_data_d = alu_result_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      rsp_data_q   <= 32'd0;
      rsp_err_q    <= 1'b0;
      alu_ctrl_q   <= 4'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_start_q  <= alu_start_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_ctrl_o    = alu_ctrl_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_start_o   = alu_start_q;
  assign busy_o        = (state_q != IDLE);

endmodule
